// File: rtl/dap_seq_pkg.sv
// Shared opcodes, command/flag layouts and FSM encoding for the DAP bit-sequence engine.
package dap_seq_pkg;

    localparam logic [2:0] SEQ_OP_OUT  = 3'd0;
    localparam logic [2:0] SEQ_OP_IN   = 3'd1;
    localparam logic [2:0] SEQ_OP_IDLE = 3'd2;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] tag;
        logic [7:0] cnt;
    } seq_cmd_t;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] tag;
        logic       err;
        logic [6:0] bits;
    } seq_flag_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= SEQ_OP_IDLE;
    endfunction

endpackage

// File: rtl/dap_sync_fifo.sv
// Single-clock command queue, zero-latency read of the head entry, registered full.
// Push while full is dropped unless a pop frees the slot in the same cycle.
module dap_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (!full_q || do_pop);
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/dap_seq_engine.sv
// Queued SWD/JTAG bit sequencer: push to first SWCLK fall is 2 clk plus the wait for sclk_pulse.
// The engine stalls in DONE until the result is taken; a full queue drops further pushes.
module dap_seq_engine
    import dap_seq_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sclk_pulse,
    input  logic              sclk_delay_pulse,
    input  logic              seq_tx_valid,
    input  logic [15:0]       seq_tx_cmd,
    input  logic [DATA_W-1:0] seq_tx_data,
    output logic              seq_tx_full,
    output logic              seq_rx_valid,
    input  logic              seq_rx_ready,
    output logic [15:0]       seq_rx_flag,
    output logic [DATA_W-1:0] seq_rx_data,
    output logic              busy,
    output logic              SWCLK_O,
    output logic              SWDIO_O,
    output logic              SWDIO_T,
    input  logic              SWDIO_I
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [15+DATA_W:0] fifo_rdata;
    logic               fifo_empty;
    seq_cmd_t           head_cmd;
    logic [DATA_W-1:0]  head_dat;
    logic               head_bad;

    logic [1:0]         state_q, state_d;
    logic               phase_q;
    logic               sclk_q, sdo_q, sdt_q;
    logic [2:0]         op_q;
    logic [4:0]         tag_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q, bit_q, bit_nxt;
    logic [DATA_W-1:0]  shift_q, rx_q;
    logic               last_bit;
    seq_flag_t          flag;

    dap_sync_fifo #(.W(16 + DATA_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (seq_tx_valid),
        .pop_i   (state_q == ST_LOAD),
        .wdata_i ({seq_tx_cmd, seq_tx_data}),
        .rdata_o (fifo_rdata),
        .full_o  (seq_tx_full),
        .empty_o (fifo_empty)
    );

    assign {head_cmd, head_dat} = fifo_rdata;
    assign head_bad = !op_legal(head_cmd.op) || (int'(head_cmd.cnt) > DATA_W);
    assign bit_nxt  = bit_q + CNT_W'(1);
    assign last_bit = (bit_nxt == cnt_q);

    // A handshake in DONE can chain straight into the next LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:  state_d = head_bad ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (sclk_pulse && phase_q && last_bit) state_d = ST_DONE;
            ST_DONE:  if (seq_rx_ready) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            sclk_q  <= 1'b1;
            sdo_q   <= 1'b1;
            sdt_q   <= 1'b0;
            op_q    <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_LOAD: begin
                    op_q    <= head_cmd.op;
                    tag_q   <= head_cmd.tag;
                    err_q   <= head_bad;
                    cnt_q   <= (head_cmd.cnt == 8'd0) ? CNT_W'(DATA_W) : CNT_W'(head_cmd.cnt);
                    bit_q   <= '0;
                    phase_q <= 1'b0;
                    shift_q <= head_dat;
                    rx_q    <= '0;
                    sdt_q   <= !head_bad && (head_cmd.op == SEQ_OP_IN);
                end
                ST_SHIFT: begin
                    if (sclk_pulse && !phase_q) begin
                        sclk_q  <= 1'b0;
                        phase_q <= 1'b1;
                        if (op_q == SEQ_OP_OUT)       sdo_q <= shift_q[0];
                        else if (op_q == SEQ_OP_IDLE) sdo_q <= 1'b0;
                    end else if (sclk_pulse) begin
                        sclk_q  <= 1'b1;
                        phase_q <= 1'b0;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_nxt;
                        if (last_bit) sdt_q <= 1'b0;
                    end else if (sclk_delay_pulse && phase_q && (op_q == SEQ_OP_IN)) begin
                        rx_q[bit_q[IDX_W-1:0]] <= SWDIO_I;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        flag      = '0;
        flag.op   = op_q;
        flag.tag  = tag_q;
        flag.err  = err_q;
        flag.bits = 7'(bit_q);
    end

    assign seq_rx_valid = (state_q == ST_DONE);
    assign seq_rx_flag  = flag;
    assign seq_rx_data  = rx_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign SWCLK_O      = sclk_q;
    assign SWDIO_O      = sdo_q;
    assign SWDIO_T      = sdt_q;

endmodule

// File: tb/tb_dap_seq_engine.sv
// Directed bench for dap_seq_engine: per-command result/bit-stream model plus literal spot checks.
module tb_dap_seq_engine;
    localparam int DATA_W = 64;

    logic              clk, resetn;
    logic              sclk_pulse, sclk_delay_pulse;
    logic              seq_tx_valid, seq_tx_full;
    logic [15:0]       seq_tx_cmd;
    logic [DATA_W-1:0] seq_tx_data;
    logic              seq_rx_valid, seq_rx_ready;
    logic [15:0]       seq_rx_flag;
    logic [DATA_W-1:0] seq_rx_data;
    logic              busy, SWCLK_O, SWDIO_O, SWDIO_T, SWDIO_I;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] flag;
        logic [63:0] data;
        logic [63:0] out;
        logic [63:0] inpat;
        int          nfalls;
    } exp_t;

    exp_t exp_mem [64];
    int   wr_idx = 0;
    int   rd_idx = 0;
    int   falls  = 0;
    logic prev_sclk = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    dap_seq_engine #(.DATA_W(DATA_W), .CMD_DEPTH(4)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .sclk_pulse       (sclk_pulse),
        .sclk_delay_pulse (sclk_delay_pulse),
        .seq_tx_valid     (seq_tx_valid),
        .seq_tx_cmd       (seq_tx_cmd),
        .seq_tx_data      (seq_tx_data),
        .seq_tx_full      (seq_tx_full),
        .seq_rx_valid     (seq_rx_valid),
        .seq_rx_ready     (seq_rx_ready),
        .seq_rx_flag      (seq_rx_flag),
        .seq_rx_data      (seq_rx_data),
        .busy             (busy),
        .SWCLK_O          (SWCLK_O),
        .SWDIO_O          (SWDIO_O),
        .SWDIO_T          (SWDIO_T),
        .SWDIO_I          (SWDIO_I)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud strobes: edge strobe every 4 clk, sample strobe halfway between.
    initial begin
        int ph;
        ph = 0;
        sclk_pulse = 1'b0;
        sclk_delay_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            sclk_pulse = (ph == 0);
            sclk_delay_pulse = (ph == 2);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [15:0] cmd, input logic [63:0] d, input logic [63:0] ip);
        exp_t        e;
        int          n;
        bit          bad;
        logic [63:0] mask;
        n    = (cmd[7:0] == 8'd0) ? 64 : int'(cmd[7:0]);
        bad  = (cmd[15:13] > 3'd2) || (n > 64);
        mask = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        e.op     = cmd[15:13];
        e.nfalls = bad ? 0 : n;
        e.flag   = {cmd[15:8], bad, bad ? 7'd0 : 7'(n)};
        e.data   = (!bad && cmd[15:13] == 3'd1) ? (ip & mask) : 64'd0;
        e.out    = d;
        e.inpat  = ip;
        return e;
    endfunction

    // Compare process: bit stream at every SWCLK fall, result at every handshake.
    always @(negedge clk) begin
        if (!resetn) begin
            rd_idx    = wr_idx;
            falls     = 0;
            prev_sclk = 1'b1;
            SWDIO_I   = 1'b0;
        end else begin
            if (prev_sclk && !SWCLK_O) begin
                if (rd_idx == wr_idx || falls >= exp_mem[rd_idx].nfalls) begin
                    check("stray_fall", 64'd1, 64'd0);
                end else begin
                    if (exp_mem[rd_idx].op == 3'd0)
                        check("swdio_out_bit", 64'(SWDIO_O), 64'(exp_mem[rd_idx].out[falls]));
                    else if (exp_mem[rd_idx].op == 3'd2)
                        check("swdio_idle_bit", 64'(SWDIO_O), 64'd0);
                    check("swdio_t_shift", 64'(SWDIO_T), 64'(exp_mem[rd_idx].op == 3'd1));
                    SWDIO_I = exp_mem[rd_idx].inpat[falls];
                    falls++;
                end
            end
            prev_sclk = SWCLK_O;
            if (seq_rx_valid && seq_rx_ready) begin
                if (rd_idx == wr_idx) begin
                    check("stray_result", 64'd1, 64'd0);
                end else begin
                    check("rx_flag", 64'(seq_rx_flag), 64'(exp_mem[rd_idx].flag));
                    check("rx_data", seq_rx_data, exp_mem[rd_idx].data);
                    check("swclk_falls", 64'(falls), 64'(exp_mem[rd_idx].nfalls));
                    check("swdio_t_done", 64'(SWDIO_T), 64'd0);
                    rd_idx++;
                    falls = 0;
                end
            end
        end
    end

    task automatic push(input logic [15:0] cmd, input logic [63:0] d, input logic [63:0] ip, input bit accept);
        seq_tx_valid = 1'b1;
        seq_tx_cmd   = cmd;
        seq_tx_data  = d;
        if (accept) begin
            exp_mem[wr_idx] = model(cmd, d, ip);
            wr_idx++;
        end
        @(posedge clk);
        #1;
        seq_tx_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (seq_rx_valid) break;
        end
        check("rx_valid_arrival", 64'(seq_rx_valid), 64'd1);
    endtask

    task automatic wait_drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (rd_idx == wr_idx && !busy) break;
        end
        check("drain_pending", 64'(wr_idx - rd_idx), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        resetn       = 1'b0;
        seq_tx_valid = 1'b0;
        seq_tx_cmd   = '0;
        seq_tx_data  = '0;
        seq_rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_swclk", 64'(SWCLK_O), 64'd1);
        check("rst_swdio_o", 64'(SWDIO_O), 64'd1);
        check("rst_swdio_t", 64'(SWDIO_T), 64'd0);
        check("rst_outs", 64'({seq_tx_full, seq_rx_valid, busy}), 64'd0);
        check("rst_flag", 64'(seq_rx_flag), 64'd0);
        check("rst_data", seq_rx_data, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // OUT 64 bits
        push(16'h0140, 64'h0123456789abcdef, 64'd0, 1'b1);
        wait_valid(1500);
        check("t1_flag", 64'(seq_rx_flag), 64'h0140);
        check("t1_data", seq_rx_data, 64'd0);
        wait_drain(100);

        // IN 8 bits; upper pattern bits must not leak into the result
        push(16'h2208, 64'd0, 64'hDEAD0000_000000A5, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!SWCLK_O) break;
        end
        check("t2_t_in_shift", 64'(SWDIO_T), 64'd1);
        wait_valid(200);
        check("t2_data", seq_rx_data, 64'h00000000_000000A5);
        check("t2_flag", 64'(seq_rx_flag), 64'h2208);
        check("t2_t_done", 64'(SWDIO_T), 64'd0);
        wait_drain(100);

        // Illegal op and oversize count
        push(16'hA308, 64'hFFFF, 64'd0, 1'b1);
        wait_valid(20);
        check("t4_op_flag", 64'(seq_rx_flag), 64'hA380);
        check("t4_op_sclk", 64'(SWCLK_O), 64'd1);
        wait_drain(20);
        push(16'h0441, 64'hFFFF, 64'd0, 1'b1);
        wait_valid(20);
        check("t4_cnt_flag", 64'(seq_rx_flag), 64'h0480);
        wait_drain(20);

        // Fill the queue behind a long command
        push(16'h0A40, 64'hF0F01234_56780F0F, 64'd0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("t3_not_full", 64'(seq_tx_full), 64'd0);
        push(16'h4000, 64'd0, 64'd0, 1'b1);
        push(16'h0103, 64'd5, 64'd0, 1'b1);
        push(16'h2202, 64'd0, 64'd2, 1'b1);
        push(16'h0301, 64'd1, 64'd0, 1'b1);
        check("t3_full", 64'(seq_tx_full), 64'd1);
        push(16'h0401, 64'd1, 64'd0, 1'b0);
        check("t3_full_after_drop", 64'(seq_tx_full), 64'd1);
        wait_drain(3000);

        // Result held while the consumer stalls
        seq_rx_ready = 1'b0;
        push(16'h0502, 64'd3, 64'd0, 1'b1);
        push(16'h0601, 64'd1, 64'd0, 1'b1);
        wait_valid(100);
        for (int k = 0; k < 20; k++) begin
            check("t5_valid", 64'(seq_rx_valid), 64'd1);
            check("t5_flag", 64'(seq_rx_flag), 64'h0502);
            check("t5_data", seq_rx_data, 64'd0);
            check("t5_no_start", 64'(SWCLK_O), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 seq_rx_ready = 1'b1;
        wait_drain(200);

        // Reset during an OUT shift
        push(16'h0720, 64'hCAFEF00D_12345678, 64'd0, 1'b1);
        repeat (100) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            if (!SWCLK_O) break;
            @(negedge clk);
        end
        check("t6_mid_shift", 64'(SWCLK_O), 64'd0);
        #2 resetn = 1'b0;
        #1;
        check("t6_swclk", 64'(SWCLK_O), 64'd1);
        check("t6_swdio_o", 64'(SWDIO_O), 64'd1);
        check("t6_swdio_t", 64'(SWDIO_T), 64'd0);
        check("t6_outs", 64'({seq_tx_full, seq_rx_valid, busy}), 64'd0);
        check("t6_flag", 64'(seq_rx_flag), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_idle_after", 64'({busy, SWCLK_O}), 64'd1);

        push(16'h0904, 64'hA, 64'd0, 1'b1);
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
